// File: rtl/edge_error_collector_pkg.sv
// rtl/edge_error_collector_pkg.sv - decoder stage codes, result header tag and collector types
package edge_error_collector_pkg;

    localparam int STAGE_WIDTH = 3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE         = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID = 3'd5;

    // Tag the output-path parser keys on to find the start of a result stream.
    localparam logic [3:0] RESULT_HEADER_TAG = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_HEADER  = 2'd2,
        ST_PAYLOAD = 2'd3
    } coll_state_t;

    function automatic int ctx_width(input int num_contexts);
        return (num_contexts > 1) ? $clog2(num_contexts) : 1;
    endfunction

endpackage

// File: rtl/edge_error_collector_popcount.sv
// rtl/edge_error_collector_popcount.sv - combinational adder-tree population count
module edge_popcount #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]             bits,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CNT_WIDTH = $clog2(WIDTH + 1);
    localparam int LEVELS    = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int PAD       = 1 << LEVELS;

    logic [PAD-1:0] padded;

    always_comb begin
        padded              = '0;
        padded[WIDTH-1:0]   = bits;
    end

    // Every partial sum is bounded by WIDTH, so one width serves all levels.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_level
        localparam int N = PAD >> l;
        logic [CNT_WIDTH-1:0] sum [N];
        for (genvar i = 0; i < N; i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign sum[i] = CNT_WIDTH'(padded[i]);
            end else begin : g_add
                assign sum[i] = g_level[l-1].sum[2*i] + g_level[l-1].sum[2*i+1];
            end
        end
    end

    assign count = g_level[LEVELS].sum[0];

endmodule

// File: rtl/edge_error_collector.sv
// rtl/edge_error_collector.sv - snapshots edge error bits and streams header plus payload words
module edge_error_collector
    import edge_error_collector_pkg::*;
#(
    parameter int NUM_EDGES    = 64,
    parameter int OUT_WIDTH    = 32,
    parameter int NUM_CONTEXTS = 2,
    localparam int CTX_WIDTH   = ctx_width(NUM_CONTEXTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STAGE_WIDTH-1:0] global_stage,
    input  logic [CTX_WIDTH-1:0]   context_id,
    input  logic [NUM_EDGES-1:0]   edge_is_error,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int CNT_WIDTH  = $clog2(NUM_EDGES + 1);
    localparam int NUM_WORDS  = (NUM_EDGES + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int SNAP_WIDTH = NUM_WORDS * OUT_WIDTH;
    localparam int IDX_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int SEL_WIDTH  = $clog2(SNAP_WIDTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    coll_state_t            state;
    coll_state_t            next_state;
    logic [STAGE_WIDTH-1:0] prev_stage;
    logic [SNAP_WIDTH-1:0]  snapshot;
    logic [CTX_WIDTH-1:0]   ctx_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   pop_cnt;
    logic [IDX_WIDTH-1:0]   word_idx;
    logic                   done_q;
    logic                   overflow_q;

    logic                   trigger;
    logic                   last_hs;
    logic                   capture;
    logic [OUT_WIDTH-1:0]   header_word;
    logic [SEL_WIDTH-1:0]   sel_base;

    edge_popcount #(
        .WIDTH (NUM_EDGES)
    ) u_popcount (
        .bits  (snapshot[NUM_EDGES-1:0]),
        .count (pop_cnt)
    );

    assign trigger = (global_stage == STAGE_RESULT_VALID) && (prev_stage != STAGE_RESULT_VALID);
    assign last_hs = (state == ST_PAYLOAD) && out_ready && (word_idx == LAST_IDX);
    // The final handshake frees the snapshot, so a trigger landing on it is taken rather than dropped.
    assign capture = trigger && ((state == ST_IDLE) || last_hs);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (capture) next_state = ST_COUNT;
            ST_COUNT:   next_state = ST_HEADER;
            ST_HEADER:  if (out_ready) next_state = ST_PAYLOAD;
            ST_PAYLOAD: if (last_hs) next_state = capture ? ST_COUNT : ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_stage <= STAGE_IDLE;
            snapshot   <= '0;
            ctx_q      <= '0;
            cnt_q      <= '0;
            word_idx   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            prev_stage <= global_stage;
            done_q     <= last_hs;
            if (trigger && !capture) begin
                overflow_q <= 1'b1;
            end
            if (capture) begin
                snapshot <= SNAP_WIDTH'(edge_is_error);
                ctx_q    <= context_id;
            end
            if (state == ST_COUNT) begin
                cnt_q <= pop_cnt;
            end
            if (state == ST_HEADER && out_ready) begin
                word_idx <= '0;
            end else if (state == ST_PAYLOAD && out_ready && (word_idx != LAST_IDX)) begin
                word_idx <= word_idx + IDX_WIDTH'(1);
            end
        end
    end

    always_comb begin
        header_word                          = '0;
        header_word[OUT_WIDTH-1 -: 4]        = RESULT_HEADER_TAG;
        header_word[OUT_WIDTH-5 -: CTX_WIDTH] = ctx_q;
        header_word[CNT_WIDTH-1:0]           = cnt_q;
    end

    assign sel_base = SEL_WIDTH'(word_idx) * SEL_WIDTH'(OUT_WIDTH);

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_HEADER: begin
                out_valid = 1'b1;
                out_data  = header_word;
            end
            ST_PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = snapshot[sel_base +: OUT_WIDTH];
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
